alu_cmd_issuer: RTL

Upstream command stage for the 16-bit accumulating ALU. It buffers opcode/operand commands from a valid/ready producer in a small FIFO and issues them to the ALU one at a time. It sequences ALU clear for RESET commands and returns each ALU result to a consumer through a single-entry valid/ready result slot. DIV and undefined opcodes are rejected locally with an error result.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_cmd_issuer_if.sv | 27 ++
 rtl/alu_cmd_fifo.sv | 69 ++++++
 rtl/alu_cmd_issuer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, issuer state encoding and default datapath width
// for the accumulating ALU command path.
package alu_pkg;

   localparam int W_DEF = 16;

   localparam logic [3:0] OP_NOOP  = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_MULT  = 4'b0011;
   localparam logic [3:0] OP_DIV   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_OR    = 4'b0110;
   localparam logic [3:0] OP_XOR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1000;
   localparam logic [3:0] OP_RESET = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_CLR    = 2'd2,
      ST_SETTLE = 2'd3
   } issuer_state_e;

   // Opcodes the ALU executes; DIV is deliberately absent and rejected locally.
   function automatic logic is_alu_op(input logic [3:0] op);
      return op inside {OP_ADD, OP_SUB, OP_MULT, OP_AND, OP_OR, OP_XOR, OP_NOT};
   endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command (producer side) and result (consumer side) valid/ready bundle
// of the ALU command issuer.
interface alu_cmd_issuer_if
   import alu_pkg::*;
#(
   parameter int W = W_DEF
);
   logic         cmd_valid;
   logic         cmd_ready;
   logic [3:0]   cmd_opcode;
   logic [W-1:0] cmd_a;
   logic [W-1:0] cmd_b;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_data;
   logic         res_err;

   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b, res_ready,
      input  cmd_ready, res_valid, res_data, res_err
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_a, cmd_b, res_ready,
      output cmd_ready, res_valid, res_data, res_err
   );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with registered count/full/empty flags; push is ignored
// when full and pop when empty.
module alu_cmd_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       clear_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   assign do_push = push & ~full_q;
   assign do_pop  = pop & ~empty_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = full_q;
   assign empty = empty_q;
endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers commands, issues them one at a time to the ALU, sequences ALU clear
// for RESET and returns each result (or a local rejection) through one slot.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       clear_n,
   alu_cmd_issuer_if.slave            bus,
   output logic                       alu_clear,
   output logic [3:0]                 alu_opcode,
   output logic [W-1:0]               alu_input1,
   output logic [W-1:0]               alu_input2,
   input  logic [W-1:0]               alu_out,
   output logic                       chain_active,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
   localparam int FW = 4 + 2*W;

   issuer_state_e state_q, state_d;
   logic          alu_clear_q, alu_clear_d;
   logic [3:0]    alu_opcode_q, alu_opcode_d;
   logic [W-1:0]  alu_in1_q, alu_in1_d;
   logic [W-1:0]  alu_in2_q, alu_in2_d;
   logic          res_valid_q, res_valid_d;
   logic [W-1:0]  res_data_q, res_data_d;
   logic          res_err_q, res_err_d;
   logic          chain_q, chain_d;

   logic          pop, fifo_full, fifo_empty, slot_free;
   logic [FW-1:0] head;
   logic [3:0]    head_op;
   logic [W-1:0]  head_a, head_b;

   alu_cmd_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .clear_n (clear_n),
      .push    (bus.cmd_valid),
      .din     ({bus.cmd_opcode, bus.cmd_a, bus.cmd_b}),
      .pop     (pop),
      .dout    (head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign {head_op, head_a, head_b} = head;
   assign slot_free = ~res_valid_q | bus.res_ready;

   always_comb begin
      state_d      = state_q;
      alu_clear_d  = 1'b0;
      alu_opcode_d = OP_NOOP;
      alu_in1_d    = alu_in1_q;
      alu_in2_d    = alu_in2_q;
      res_valid_d  = res_valid_q & ~bus.res_ready;
      res_data_d   = res_data_q;
      res_err_d    = res_err_q;
      chain_d      = chain_q;
      pop          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && slot_free) begin
               pop = 1'b1;
               if (is_alu_op(head_op)) begin
                  state_d      = ST_ISSUE;
                  alu_opcode_d = head_op;
                  alu_in1_d    = head_a;
                  alu_in2_d    = head_b;
               end else if (head_op == OP_RESET) begin
                  state_d      = ST_CLR;
                  alu_clear_d  = 1'b1;
                  alu_opcode_d = OP_RESET;
               end else if (head_op != OP_NOOP) begin
                  res_valid_d = 1'b1;
                  res_err_d   = 1'b1;
                  res_data_d  = '0;
               end
            end
         end
         // The slot is guaranteed empty here: it was free when this command popped.
         ST_ISSUE: begin
            state_d     = ST_IDLE;
            res_valid_d = 1'b1;
            res_err_d   = 1'b0;
            res_data_d  = alu_out;
            chain_d     = 1'b1;
         end
         ST_CLR: begin
            state_d = ST_SETTLE;
            chain_d = 1'b0;
         end
         ST_SETTLE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q      <= ST_CLR;
         alu_clear_q  <= 1'b1;
         alu_opcode_q <= OP_NOOP;
         alu_in1_q    <= '0;
         alu_in2_q    <= '0;
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         res_err_q    <= 1'b0;
         chain_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_clear_q  <= alu_clear_d;
         alu_opcode_q <= alu_opcode_d;
         alu_in1_q    <= alu_in1_d;
         alu_in2_q    <= alu_in2_d;
         res_valid_q  <= res_valid_d;
         res_data_q   <= res_data_d;
         res_err_q    <= res_err_d;
         chain_q      <= chain_d;
      end
   end

   assign bus.cmd_ready = ~fifo_full;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_err   = res_err_q;
   assign alu_clear     = alu_clear_q;
   assign alu_opcode    = alu_opcode_q;
   assign alu_input1    = alu_in1_q;
   assign alu_input2    = alu_in2_q;
   assign chain_active  = chain_q;
endmodule
